clk_gate_ctrl: RTL

- Idle-driven controller that produces the enable for a downstream glitch-free clock-gate cell (BUFGCE/BUFHCE-based gating primitive).
- Runs on the free-running clock feeding that cell. Watches activity of the gated domain and gates only after a quiesce request/acknowledge handshake.
- Ungates on wake request and reports when the gated clock is stable again.
- Also keeps a saturating count of gating events for software visibility.

---
 rtl/clk_gate_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/clk_gate_ctrl.sv
// Idle-driven enable generator for a glitch-free clock-gate cell; gates only after a quiesce req/ack handshake.
// All outputs are registered. Wake-to-ready takes WAKE_CYCLES+1 edges, and no new gating can start until RUN is re-entered.
module clk_gate_ctrl #(
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             busy_i,
    input  logic             wake_i,
    input  logic             quiesce_ack_i,
    output logic             quiesce_req_o,
    output logic             clk_en_o,
    output logic             clk_ready_o,
    output logic             gated_o,
    output logic [CNT_W-1:0] gate_count_o
);

    localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);
    localparam int unsigned WW = $clog2(WAKE_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [IW-1:0]    r_idle_cnt;
    logic [WW-1:0]    r_wake_cnt;
    logic             r_quiesce_req;
    logic             r_clk_en;
    logic             r_clk_ready;
    logic             r_gated;
    logic [CNT_W-1:0] r_gate_cnt;

    logic w_idle;
    logic w_abort;

    assign w_idle  = enable_i & ~busy_i & ~wake_i;
    assign w_abort = busy_i | wake_i | ~enable_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= RUN;
            r_idle_cnt    <= '0;
            r_wake_cnt    <= '0;
            r_quiesce_req <= 1'b0;
            r_clk_en      <= 1'b1;
            r_clk_ready   <= 1'b1;
            r_gated       <= 1'b0;
            r_gate_cnt    <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (!w_idle) begin
                        r_idle_cnt <= '0;
                    end else if (r_idle_cnt == IDLE_LAST) begin
                        r_idle_cnt    <= '0;
                        r_quiesce_req <= 1'b1;
                        r_state       <= DRAIN;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    // Abort wins over a coincident ack so a busy domain is never stopped.
                    if (w_abort) begin
                        r_quiesce_req <= 1'b0;
                        r_idle_cnt    <= '0;
                        r_state       <= RUN;
                    end else if (quiesce_ack_i) begin
                        r_clk_en    <= 1'b0;
                        r_clk_ready <= 1'b0;
                        r_gated     <= 1'b1;
                        if (r_gate_cnt != {CNT_W{1'b1}}) begin
                            r_gate_cnt <= r_gate_cnt + 1'b1;
                        end
                        r_state <= GATED;
                    end
                end
                GATED: begin
                    if (wake_i || !enable_i) begin
                        r_clk_en      <= 1'b1;
                        r_quiesce_req <= 1'b0;
                        r_gated       <= 1'b0;
                        r_wake_cnt    <= '0;
                        r_state       <= WAKE;
                    end
                end
                WAKE: begin
                    if (r_wake_cnt == WAKE_LAST) begin
                        r_clk_ready <= 1'b1;
                        r_idle_cnt  <= '0;
                        r_state     <= RUN;
                    end else begin
                        r_wake_cnt <= r_wake_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign quiesce_req_o = r_quiesce_req;
    assign clk_en_o      = r_clk_en;
    assign clk_ready_o   = r_clk_ready;
    assign gated_o       = r_gated;
    assign gate_count_o  = r_gate_cnt;

endmodule
